// File: rtl/cache_pkg.sv
// cache_pkg: shared widths and types for the cache / write-buffer / RAM slice.
//   DATA_W, ADDR_W, RAM_AW : datapath widths
//   CACHE_LINES, RAM_WORDS : geometry of the cache and backing RAM
//   wbuf_state_t           : write-buffer drain FSM states
//   wbuf_entry_t           : one buffered store (valid, reduced index, data)
package cache_pkg;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int RAM_AW      = 12;
  localparam int CACHE_LINES = 64;
  localparam int RAM_WORDS   = 4096;

  typedef enum logic {IDLE, BUSY} wbuf_state_t;

  typedef struct packed {
    logic              valid;
    logic [RAM_AW-1:0] idx;
    logic [DATA_W-1:0] data;
  } wbuf_entry_t;
endpackage

// File: rtl/cache_write_buffer_fwd.sv
// wbuf_fwd_match: combinational youngest-match search over the buffer.
//   i_vld/i_idx/i_data : entry storage, slot-indexed
//   i_head             : slot of the oldest entry
//   i_addr             : reduced lookup index
//   o_hit/o_data       : match flag and data of the youngest match (0 on miss)
module wbuf_fwd_match #(
  parameter int DATA_W = 32,
  parameter int RAM_AW = 12,
  parameter int DEPTH  = 4
) (
  input  logic [DEPTH-1:0]             i_vld,
  input  logic [DEPTH-1:0][RAM_AW-1:0] i_idx,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_data,
  input  logic [$clog2(DEPTH)-1:0]     i_head,
  input  logic [RAM_AW-1:0]            i_addr,
  output logic                         o_hit,
  output logic [DATA_W-1:0]            o_data
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] w_slot;

  // Walk oldest -> youngest; a later match overrides, so the youngest wins.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = i_head + PW'(k);
      if (i_vld[w_slot] && (i_idx[w_slot] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_data[w_slot];
      end
    end
  end
endmodule

// File: rtl/cache_write_buffer.sv
// cache_write_buffer: posted-write FIFO between the cache and the 4096-word RAM.
//   wr_valid/wr_ready/wr_addr/wr_data : store intake (one-cycle completion)
//   fwd_addr/fwd_hit/fwd_data         : combinational read forwarding
//   ram_we/ram_addr/ram_wdata/ram_ack : in-order drain to RAM
//   count/full/empty                  : occupancy, in-flight entry included
// Optional: define WBUF_COALESCE_EN to merge a store into a matching
// buffered entry that is not yet in flight.
module cache_write_buffer #(
  parameter int DATA_W = cache_pkg::DATA_W,
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int RAM_AW = cache_pkg::RAM_AW,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic                     ram_we,
  output logic [RAM_AW-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic                     ram_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  import cache_pkg::*;
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0]             r_vld;
  logic [DEPTH-1:0][RAM_AW-1:0] r_idx;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [PW-1:0]                r_rd_ptr, r_wr_ptr;
  logic [PW:0]                  r_count;
  wbuf_state_t                  r_state, w_nxt_state;
  logic                         r_ram_we;
  logic [RAM_AW-1:0]            r_ram_addr;
  logic [DATA_W-1:0]            r_ram_wdata;

  logic              w_full, w_empty, w_coal, w_accept, w_alloc, w_pop;
  logic              w_load, w_load_hit;
  logic [PW-1:0]     w_coal_slot, w_wr_slot, w_load_slot;
  logic [RAM_AW-1:0] w_wr_idx, w_load_idx;
  logic [DATA_W-1:0] w_load_data;
  logic              w_unused_addr;

  assign w_wr_idx      = wr_addr[RAM_AW-1:0];
  assign w_unused_addr = ^{wr_addr[ADDR_W-1:RAM_AW], fwd_addr[ADDR_W-1:RAM_AW]};
  assign w_full        = (r_count == (PW+1)'(DEPTH));
  assign w_empty       = (r_count == '0);

`ifdef WBUF_COALESCE_EN
  // Any valid entry except the one already handed to RAM may absorb the store.
  always_comb begin
    w_coal      = 1'b0;
    w_coal_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_idx[i] == w_wr_idx) &&
          !((r_state == BUSY) && (PW'(i) == r_rd_ptr))) begin
        w_coal      = 1'b1;
        w_coal_slot = PW'(i);
      end
    end
  end
`else
  assign w_coal      = 1'b0;
  assign w_coal_slot = r_wr_ptr;
`endif

  assign wr_ready  = !w_full || w_coal;
  assign w_accept  = wr_valid && wr_ready;
  assign w_alloc   = w_accept && !w_coal;
  assign w_wr_slot = w_coal ? w_coal_slot : r_wr_ptr;
  assign w_pop     = (r_state == BUSY) && ram_ack;

  // Drain FSM: choose when to (re)load the RAM request and which slot feeds it.
  always_comb begin
    w_nxt_state = r_state;
    w_load      = 1'b0;
    w_load_slot = r_rd_ptr;
    if (r_state == IDLE) begin
      if (!w_empty) begin
        w_load      = 1'b1;
        w_nxt_state = BUSY;
      end
    end else if (ram_ack) begin
      if ((r_count != (PW+1)'(1)) || w_alloc) begin
        w_load      = 1'b1;
        w_load_slot = r_rd_ptr + 1'b1;
      end else begin
        w_nxt_state = IDLE;
      end
    end
  end

  // A store landing in the slot being loaded this edge must be bypassed,
  // otherwise RAM would get the pre-store contents.
  assign w_load_hit  = w_accept && (w_wr_slot == w_load_slot);
  assign w_load_idx  = w_load_hit ? w_wr_idx : r_idx[w_load_slot];
  assign w_load_data = w_load_hit ? wr_data  : r_data[w_load_slot];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_vld       <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      if (w_accept) r_vld[w_wr_slot] <= 1'b1;
      if (w_alloc)  r_wr_ptr <= r_wr_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_alloc) - (PW+1)'(w_pop);
      if (w_load) begin
        r_ram_we    <= 1'b1;
        r_ram_addr  <= w_load_idx;
        r_ram_wdata <= w_load_data;
      end else if (w_pop) begin
        r_ram_we <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; r_vld qualifies every slot.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx[w_wr_slot]  <= w_wr_idx;
      r_data[w_wr_slot] <= wr_data;
    end
  end

  wbuf_fwd_match #(.DATA_W(DATA_W), .RAM_AW(RAM_AW), .DEPTH(DEPTH)) u_fwd (
    .i_vld  (r_vld),
    .i_idx  (r_idx),
    .i_data (r_data),
    .i_head (r_rd_ptr),
    .i_addr (fwd_addr[RAM_AW-1:0]),
    .o_hit  (fwd_hit),
    .o_data (fwd_data)
  );

  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
endmodule

// File: tb/tb_cache_write_buffer.sv
module tb_cache_write_buffer;
  logic        clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0, ram_ack = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0, fwd_addr = '0;
  logic        wr_ready, fwd_hit, ram_we, full, empty;
  logic [31:0] fwd_data, ram_wdata;
  logic [11:0] ram_addr;
  logic [2:0]  count;

  int n_chk = 0, n_pass = 0;
  logic [11:0] log_a[$];
  logic [31:0] log_d[$];
  logic [11:0] ea[$];
  logic [31:0] ed[$];

  cache_write_buffer #(.DATA_W(32), .ADDR_W(32), .RAM_AW(12), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .fwd_addr(fwd_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ack(ram_ack),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // RAM side: record every accepted write
  always @(posedge clk)
    if (rst_n && ram_we && ram_ack) begin
      log_a.push_back(ram_addr);
      log_d.push_back(ram_wdata);
    end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_chk++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags got e%b f%b exp e1 f0", empty, full); else n_pass++;
    n_chk++; if (ram_we !== 1'b0 || ram_addr !== 12'd0 || ram_wdata !== 32'd0)
      $display("FAIL reset_ram got we%b %0d/%0d exp we0 0/0", ram_we, ram_addr, ram_wdata); else n_pass++;
    n_chk++; if (wr_ready !== 1'b1 || fwd_hit !== 1'b0) $display("FAIL reset_rdy got rdy%b hit%b exp 1 0", wr_ready, fwd_hit); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    ram_ack = 1'b0;
    push(32'd0, 32'd14528);
    n_chk++; if (ram_we !== 1'b0 || count !== 3'd1) $display("FAIL mid_pre got we%b cnt%0d exp we0 cnt1", ram_we, count); else n_pass++;
    tick();
    n_chk++; if (ram_we !== 1'b1) $display("FAIL mid_we got %b exp 1", ram_we); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (ram_we !== 1'b0 || empty !== 1'b1 || count !== 3'd0)
      $display("FAIL mid_async got we%b e%b cnt%0d exp we0 e1 cnt0", ram_we, empty, count); else n_pass++;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_order_latency();
    log_a.delete(); log_d.delete();
    ram_ack = 1'b1;
    push(32'd0, 32'd14528);
    n_chk++; if (ram_we !== 1'b0) $display("FAIL lat_n got we%b exp 0", ram_we); else n_pass++;
    push(32'd2816867292, 32'd526421);
    n_chk++; if (ram_we !== 1'b1 || ram_addr !== 12'd0 || ram_wdata !== 32'd14528)
      $display("FAIL lat_n1 got we%b %0d<-%0d exp we1 0<-14528", ram_we, ram_addr, ram_wdata); else n_pass++;
    push(32'd1001425, 32'd25369366);
    repeat (5) tick();
    ram_ack = 1'b0;
    n_chk++; if (empty !== 1'b1 || ram_we !== 1'b0) $display("FAIL order_idle got e%b we%b exp e1 we0", empty, ram_we); else n_pass++;
    ea = '{12'd0, 12'd3036, 12'd2001};
    ed = '{32'd14528, 32'd526421, 32'd25369366};
    n_chk++; if (log_a.size() != ea.size()) $display("FAIL order_n got %0d exp %0d", log_a.size(), ea.size()); else n_pass++;
    for (int i = 0; i < ea.size() && i < log_a.size(); i++) begin
      n_chk++; if (log_a[i] !== ea[i] || log_d[i] !== ed[i])
        $display("FAIL order[%0d] got %0d<-%0d exp %0d<-%0d", i, log_a[i], log_d[i], ea[i], ed[i]); else n_pass++;
    end
  endtask

  task automatic test_full();
    log_a.delete(); log_d.delete();
    ram_ack = 1'b0;
    for (int i = 0; i < 4; i++) push(32'(10 * (i + 1)), 32'(100 + i));
    n_chk++; if (full !== 1'b1 || count !== 3'd4 || wr_ready !== 1'b0)
      $display("FAIL full_state got f%b cnt%0d rdy%b exp f1 cnt4 rdy0", full, count, wr_ready); else n_pass++;
    push(32'd50, 32'd104);
    n_chk++; if (count !== 3'd4) $display("FAIL full_reject got cnt%0d exp 4", count); else n_pass++;
    ram_ack = 1'b1; tick(); ram_ack = 1'b0;
    n_chk++; if (count !== 3'd3 || wr_ready !== 1'b1 || full !== 1'b0 || ram_we !== 1'b1)
      $display("FAIL full_pop got cnt%0d rdy%b f%b we%b exp cnt3 rdy1 f0 we1", count, wr_ready, full, ram_we); else n_pass++;
    ram_ack = 1'b1; repeat (6) tick(); ram_ack = 1'b0;
    n_chk++; if (empty !== 1'b1) $display("FAIL full_drain got e%b exp 1", empty); else n_pass++;
    ea = '{12'd10, 12'd20, 12'd30, 12'd40};
    ed = '{32'd100, 32'd101, 32'd102, 32'd103};
    n_chk++; if (log_a.size() != ea.size()) $display("FAIL full_n got %0d exp %0d", log_a.size(), ea.size()); else n_pass++;
    for (int i = 0; i < ea.size() && i < log_a.size(); i++) begin
      n_chk++; if (log_a[i] !== ea[i] || log_d[i] !== ed[i])
        $display("FAIL full_log[%0d] got %0d<-%0d exp %0d<-%0d", i, log_a[i], log_d[i], ea[i], ed[i]); else n_pass++;
    end
  endtask

  task automatic test_forward();
    log_a.delete(); log_d.delete();
    ram_ack = 1'b0;
    fwd_addr = 32'd777;
    wr_valid = 1'b1; wr_addr = 32'd777; wr_data = 32'd9;
    #1;
    n_chk++; if (fwd_hit !== 1'b0) $display("FAIL fwd_same_cycle got hit%b exp 0", fwd_hit); else n_pass++;
    tick(); wr_valid = 1'b0;
    n_chk++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd9) $display("FAIL fwd_next got hit%b %0d exp 1 9", fwd_hit, fwd_data); else n_pass++;
    push(32'd3036, 32'd526421);
    push(32'd3036, 32'd14528);
    fwd_addr = 32'd2816867292; #1;
    n_chk++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd14528) $display("FAIL fwd_young got hit%b %0d exp 1 14528", fwd_hit, fwd_data); else n_pass++;
    fwd_addr = 32'd5; #1;
    n_chk++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) $display("FAIL fwd_miss got hit%b %0d exp 0 0", fwd_hit, fwd_data); else n_pass++;
`ifdef WBUF_COALESCE_EN
    n_chk++; if (count !== 3'd2) $display("FAIL fwd_cnt got %0d exp 2", count); else n_pass++;
    ea = '{12'd777, 12'd3036};
    ed = '{32'd9, 32'd14528};
`else
    n_chk++; if (count !== 3'd3) $display("FAIL fwd_cnt got %0d exp 3", count); else n_pass++;
    ea = '{12'd777, 12'd3036, 12'd3036};
    ed = '{32'd9, 32'd526421, 32'd14528};
`endif
    ram_ack = 1'b1; repeat (5) tick(); ram_ack = 1'b0;
    n_chk++; if (log_a.size() != ea.size()) $display("FAIL fwd_n got %0d exp %0d", log_a.size(), ea.size()); else n_pass++;
    for (int i = 0; i < ea.size() && i < log_a.size(); i++) begin
      n_chk++; if (log_a[i] !== ea[i] || log_d[i] !== ed[i])
        $display("FAIL fwd_log[%0d] got %0d<-%0d exp %0d<-%0d", i, log_a[i], log_d[i], ea[i], ed[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    log_a.delete(); log_d.delete();
    ram_ack = 1'b1;
    push(32'd100, 32'd1);
    push(32'd101, 32'd2);
    n_chk++; if (count !== 3'd2) $display("FAIL b2b_fill got cnt%0d exp 2", count); else n_pass++;
    for (int i = 2; i < 6; i++) begin
      push(32'(100 + i), 32'(1 + i));
      n_chk++; if (count !== 3'd2) $display("FAIL b2b_cnt[%0d] got %0d exp 2", i, count); else n_pass++;
    end
    repeat (5) tick();
    ram_ack = 1'b0;
    n_chk++; if (empty !== 1'b1) $display("FAIL b2b_drain got e%b exp 1", empty); else n_pass++;
    n_chk++; if (log_a.size() != 6) $display("FAIL b2b_n got %0d exp 6", log_a.size()); else n_pass++;
    for (int i = 0; i < 6 && i < log_a.size(); i++) begin
      n_chk++; if (log_a[i] !== 12'(100 + i) || log_d[i] !== 32'(1 + i))
        $display("FAIL b2b_log[%0d] got %0d<-%0d exp %0d<-%0d", i, log_a[i], log_d[i], 100 + i, 1 + i); else n_pass++;
    end
  endtask

  task automatic test_dup_store();
    log_a.delete(); log_d.delete();
    ram_ack = 1'b0;
    push(32'd50, 32'd77);
    push(32'd1001425, 32'd25369366);
    n_chk++; if (count !== 3'd2) $display("FAIL dup_pre got cnt%0d exp 2", count); else n_pass++;
    push(32'd2001, 32'd14528);
    fwd_addr = 32'd2001; #1;
    n_chk++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd14528) $display("FAIL dup_fwd got hit%b %0d exp 1 14528", fwd_hit, fwd_data); else n_pass++;
`ifdef WBUF_COALESCE_EN
    n_chk++; if (count !== 3'd2) $display("FAIL dup_cnt got %0d exp 2", count); else n_pass++;
    ea = '{12'd50, 12'd2001};
    ed = '{32'd77, 32'd14528};
`else
    n_chk++; if (count !== 3'd3) $display("FAIL dup_cnt got %0d exp 3", count); else n_pass++;
    ea = '{12'd50, 12'd2001, 12'd2001};
    ed = '{32'd77, 32'd25369366, 32'd14528};
`endif
    ram_ack = 1'b1; repeat (5) tick(); ram_ack = 1'b0;
    n_chk++; if (empty !== 1'b1) $display("FAIL dup_drain got e%b exp 1", empty); else n_pass++;
    n_chk++; if (log_a.size() != ea.size()) $display("FAIL dup_n got %0d exp %0d", log_a.size(), ea.size()); else n_pass++;
    for (int i = 0; i < ea.size() && i < log_a.size(); i++) begin
      n_chk++; if (log_a[i] !== ea[i] || log_d[i] !== ed[i])
        $display("FAIL dup_log[%0d] got %0d<-%0d exp %0d<-%0d", i, log_a[i], log_d[i], ea[i], ed[i]); else n_pass++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    #10 rst_n = 1'b1;
    tick();
    test_reset_mid_drain();
    test_order_latency();
    test_full();
    test_forward();
    test_back_to_back();
    test_dup_store();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
